// File: rtl/vmem_reader.sv
`default_nettype none
// ============================================================================
//  Module      : vmem_reader
//  Description : Read-side initiator for the memory's secondary read port.
//                Walks a fixed window of WORDS words starting at BASE,
//                captures each word and streams it out byte by byte, MSB
//                first, on a valid/ready interface. Optional looping, abort
//                on stop, done pulse and completed-frame counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module vmem_reader #(
    parameter logic [31:0] BASE  = 32'h0000_0080,
    parameter int          WORDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    output logic [31:0] va,
    input  logic [31:0] vd,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic [7:0]  frames
);

    localparam int              c_IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(WORDS - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_SEND  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [c_IDXW-1:0] r_idx;
    logic [1:0]        r_bcnt;
    logic [31:0]       r_sh;
    logic [7:0]        r_frames;

    logic w_hs;

    // A byte is consumed when the sink accepts while we present in SEND.
    assign w_hs = (r_state == c_SEND) && out_ready;

    // Address comes from the index register only: no input-to-va path.
    assign va = BASE + {{(30 - c_IDXW){1'b0}}, r_idx, 2'b00};

    // Stream and status outputs are pure decodes of registered state.
    assign out_data  = r_sh[31:24];
    assign out_valid = (r_state == c_SEND);
    assign busy      = (r_state != c_IDLE);
    assign done      = (r_state == c_DONE);
    assign frames    = r_frames;

    // Frame sequencer: fetch a word, shift it out, advance or finish.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= c_IDLE;
            r_idx    <= '0;
            r_bcnt   <= 2'd0;
            r_sh     <= 32'd0;
            r_frames <= 8'd0;
        end else if (stop) begin
            // Abort wins over everything, including a final handshake.
            r_state <= c_IDLE;
            r_idx   <= '0;
            r_bcnt  <= 2'd0;
            r_sh    <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_FETCH;
                        r_idx   <= '0;
                    end
                end
                c_FETCH: begin
                    // Sees RAM content of this cycle; a same-edge write is missed.
                    r_sh    <= vd;
                    r_bcnt  <= 2'd0;
                    r_state <= c_SEND;
                end
                c_SEND: begin
                    if (w_hs) begin
                        r_sh   <= {r_sh[23:0], 8'h00};
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            if (r_idx != c_LAST) begin
                                r_idx   <= r_idx + 1'b1;
                                r_state <= c_FETCH;
                            end else begin
                                r_frames <= r_frames + 8'd1;
                                if (loop) begin
                                    r_idx   <= '0;
                                    r_state <= c_FETCH;
                                end else begin
                                    r_state <= c_DONE;
                                end
                            end
                        end
                    end
                end
                default: begin
                    r_idx   <= '0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vmem_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vmem_reader
//  Description : Directed self-checking bench for vmem_reader with a small
//                64-word RAM model (combinational read, clocked write).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vmem_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic [31:0] va;
    logic [31:0] vd;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  frames;

    logic        we = 1'b0;
    logic [5:0]  wa = 6'd0;
    logic [31:0] wd = 32'd0;
    logic [31:0] mem [0:63];

    int n_err = 0;
    int n_chk = 0;
    int dcnt;
    int dm;

    always #5 clk = ~clk;

    // RAM model: processor-port write on the edge, secondary port read combinationally.
    always @(posedge clk) if (we) mem[wa] <= wd;
    assign vd = mem[va[7:2]];

    vmem_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .va        (va),
        .vd        (vd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .frames    (frames)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected byte i of the stream; word 2 may carry an override value.
    function automatic logic [7:0] exp_byte(input int i, input logic [31:0] w2, input bit ovr);
        int k;
        int j;
        logic [31:0] w;
        k = (i / 4) % 16;
        j = i % 4;
        w = 32'h0001_0203 + 32'h0404_0404 * k;
        if (ovr && k == 2) w = w2;
        return w[31 - 8*j -: 8];
    endfunction

    task automatic load_mem();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            we = 1'b1;
            wa = 6'(32 + k);
            wd = 32'h0001_0203 + 32'h0404_0404 * k;
        end
        @(negedge clk);
        we = 1'b0;
    endtask

    // Pulses start, then collects nbytes while driving ready per mode
    // (0: always ready, 1: pseudo-random). Optional loop, stop, RAM write
    // at cycle wr_m, and a spurious start at cycle bs_m.
    task automatic run(input int nbytes, input int mode, input int loop_bytes,
                       input int stop_at, input int wr_m, input logic [31:0] wr_d,
                       input int bs_m, input logic [31:0] w2, input bit ovr,
                       output int done_cnt, output int done_m);
        int got = 0;
        int m = 0;
        int tail = 0;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [7:0] pd = 8'h00;
        bit stopped = 1'b0;
        done_cnt = 0;
        done_m = 0;
        @(negedge clk);
        start = 1'b1;
        out_ready = (mode == 0);
        loop = (loop_bytes > 0);
        while (1) begin
            @(negedge clk);
            m++;
            start = (m == bs_m);
            we = (m == wr_m);
            wa = 6'd34;
            wd = wr_d;
            if (stopped) begin
                stop = 1'b0;
                check("stop_busy", 32'(busy), 32'd0);
                check("stop_valid", 32'(out_valid), 32'd0);
                check("stop_done", 32'(done), 32'd0);
                break;
            end
            if (done) begin
                done_cnt++;
                if (done_m == 0) done_m = m;
            end
            if (pv && !pr) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(pd));
            end
            out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            loop = (got < loop_bytes);
            if (out_valid && out_ready && got < nbytes) begin
                check($sformatf("byte%0d", got), 32'(out_data), 32'(exp_byte(got, w2, ovr)));
                check($sformatf("va%0d", got), va, 32'h80 + 32'(4 * ((got / 4) % 16)));
                if (mode == 0 && got % 64 == 0)
                    check($sformatf("frame_start%0d", got / 64), 32'(m), 32'(2 + 80 * (got / 64)));
                if (got == stop_at) begin
                    stop = 1'b1;
                    stopped = 1'b1;
                end
                got++;
            end
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
            if (got == nbytes && !stopped) begin
                tail++;
                if (tail == 4) break;
            end
            if (m > 4000) begin
                check("timeout_bytes", 32'(got), 32'(nbytes));
                break;
            end
        end
        out_ready = 1'b0;
        loop = 1'b0;
        we = 1'b0;
        stop = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_va", va, 32'h80);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_frames", 32'(frames), 32'd0);
        reset = 1'b1;
        load_mem();

        // Basic frame: bytes 00..3F, done at cycle 81, one frame counted
        run(64, 0, 0, -1, 0, 32'd0, 0, 32'd0, 1'b0, dcnt, dm);
        check("basic_done_cnt", 32'(dcnt), 32'd1);
        check("basic_done_cycle", 32'(dm), 32'd81);
        check("basic_frames", 32'(frames), 32'd1);

        // Backpressure plus a spurious start while busy
        run(64, 1, 0, -1, 0, 32'd0, 20, 32'd0, 1'b0, dcnt, dm);
        check("bp_done_cnt", 32'(dcnt), 32'd1);
        check("bp_frames", 32'(frames), 32'd2);
        check("bp_idle", 32'(busy), 32'd0);

        // Reset mid-SEND
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("mid_valid", 32'(out_valid), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b0;
        check("mr_va", va, 32'h80);
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_data", 32'(out_data), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_done", 32'(done), 32'd0);
        check("mr_frames", 32'(frames), 32'd0);

        // Loop for three frames, then finish the fourth
        run(256, 0, 192, -1, 0, 32'd0, 0, 32'd0, 1'b0, dcnt, dm);
        check("loop_done_cnt", 32'(dcnt), 32'd1);
        check("loop_done_cycle", 32'(dm), 32'd321);
        check("loop_frames", 32'(frames), 32'd4);

        // Stop on the final handshake: no done, frame not counted
        run(64, 0, 0, 63, 0, 32'd0, 0, 32'd0, 1'b0, dcnt, dm);
        check("stop_done_cnt", 32'(dcnt), 32'd0);
        check("stop_frames", 32'(frames), 32'd4);
        @(negedge clk);
        check("stop_done_after", 32'(done), 32'd0);

        // start and stop together in IDLE
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        check("ss_busy0", 32'(busy), 32'd0);
        @(negedge clk);
        check("ss_busy1", 32'(busy), 32'd0);
        check("ss_valid", 32'(out_valid), 32'd0);

        // Write committed on the FETCH edge of word 34: old value streamed
        run(64, 0, 0, -1, 11, 32'hDEAD_BEEF, 0, 32'd0, 1'b0, dcnt, dm);
        check("wc_same_frames", 32'(frames), 32'd5);

        // Restore word 34, then write one cycle before its FETCH
        @(negedge clk);
        we = 1'b1;
        wa = 6'd34;
        wd = 32'h0809_0A0B;
        @(negedge clk);
        we = 1'b0;
        run(64, 0, 0, -1, 10, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b1, dcnt, dm);
        check("wc_early_frames", 32'(frames), 32'd6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
